iterative_divider: RTL and testbench

- Multi-cycle signed/unsigned integer divider for the i16 ALU; executes DIV/DIVU/REM/REMU.
- Upstream: operand magnitudes are taken with AbsoluteValue. Downstream: the unsigned quotient and remainder are re-signed with GiveSign.
- Core is a restoring shift-subtract loop that produces one quotient bit per clock.
- Sits beside the combinational ALU; the control unit stalls on Busy.

---
 rtl/iterative_divider.sv | 167 ++++++++++++++++
 tb/tb_iterative_divider.sv | 129 ++++++++++++
 2 files changed

// File: rtl/iterative_divider.sv
// Multi-cycle restoring shift-subtract divider for DIV/DIVU/REM/REMU.
// One quotient bit per clock; results and flags are registered at the FIX step.
module iterative_divider #(
    parameter int l = 16
) (
    input  logic         Clock,
    input  logic         Reset,
    input  logic         Start,
    input  logic         Signed,
    input  logic [l-1:0] Dividend,
    input  logic [l-1:0] Divisor,
    output logic         Busy,
    output logic         Done,
    output logic [l-1:0] Quotient,
    output logic [l-1:0] Remainder,
    output logic         DivByZero,
    output logic         Overflow
);

    localparam int CW = $clog2(l);
    localparam logic [CW-1:0] LAST_CNT = CW'(l - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [l-1:0]  ONE      = {{(l-1){1'b0}}, 1'b1};
    localparam logic [l-1:0]  ALL_ONES = {l{1'b1}};
    localparam logic [l-1:0]  ALL_ZERO = {l{1'b0}};
    localparam logic [l-1:0]  MIN_NEG  = {1'b1, {(l-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t          state_r, state_s;
    logic [CW-1:0]   cnt_r;
    logic [l-1:0]    d_r;          // dividend magnitude, becomes quotient magnitude
    logic [l-1:0]    p_r;          // partial remainder magnitude
    logic [l-1:0]    div_mag_r;
    logic            qneg_r, rneg_r, zero_r, ovf_r;
    logic            busy_r, done_r, dbz_r, ovfl_r;
    logic [l-1:0]    quot_r, rem_r;
    logic [l:0]      p_shift_s;
    logic [l-1:0]    p_step_s;
    logic            qbit_s;
    logic [l-1:0]    q_res_s, r_res_s;

    function automatic logic [l-1:0] abs_value(input logic sgn, input logic [l-1:0] v);
        return (sgn & v[l-1]) ? (~v + ONE) : v;
    endfunction

    function automatic logic [l-1:0] give_sign(input logic neg, input logic [l-1:0] mag);
        return neg ? (~mag + ONE) : mag;
    endfunction

    // state register
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (Start) state_s = RUN;
                else       state_s = IDLE;
            end
            RUN: begin
                if (cnt_r == LAST_CNT) state_s = FIX;
                else                   state_s = RUN;
            end
            FIX:     state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // one restoring step; the true difference always fits in l bits
    always_comb begin
        p_shift_s = {p_r, d_r[l-1]};
        p_step_s  = p_shift_s[l-1:0];
        qbit_s    = 1'b0;
        if (p_shift_s >= {1'b0, div_mag_r}) begin
            p_step_s = p_shift_s[l-1:0] - div_mag_r;
            qbit_s   = 1'b1;
        end else begin
            p_step_s = p_shift_s[l-1:0];
            qbit_s   = 1'b0;
        end
    end

    // re-sign results; zero divisor forces an all-ones quotient
    always_comb begin
        r_res_s = give_sign(rneg_r, p_r);
        if (zero_r) begin
            q_res_s = ALL_ONES;
        end else begin
            q_res_s = give_sign(qneg_r, d_r);
        end
    end

    // operand latch, iteration datapath and registered outputs
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            cnt_r     <= {CW{1'b0}};
            d_r       <= ALL_ZERO;
            p_r       <= ALL_ZERO;
            div_mag_r <= ALL_ZERO;
            qneg_r    <= 1'b0;
            rneg_r    <= 1'b0;
            zero_r    <= 1'b0;
            ovf_r     <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            dbz_r     <= 1'b0;
            ovfl_r    <= 1'b0;
            quot_r    <= ALL_ZERO;
            rem_r     <= ALL_ZERO;
        end else begin
            case (state_r)
                IDLE: begin
                    done_r <= 1'b0;
                    if (Start) begin
                        d_r       <= abs_value(Signed, Dividend);
                        div_mag_r <= abs_value(Signed, Divisor);
                        qneg_r    <= Signed & (Dividend[l-1] ^ Divisor[l-1]);
                        rneg_r    <= Signed & Dividend[l-1];
                        zero_r    <= (Divisor == ALL_ZERO);
                        ovf_r     <= Signed & (Dividend == MIN_NEG) & (Divisor == ALL_ONES);
                        p_r       <= ALL_ZERO;
                        cnt_r     <= {CW{1'b0}};
                        busy_r    <= 1'b1;
                    end
                end
                RUN: begin
                    done_r <= 1'b0;
                    p_r    <= p_step_s;
                    d_r    <= {d_r[l-2:0], qbit_s};
                    cnt_r  <= cnt_r + CNT_ONE;
                end
                FIX: begin
                    quot_r <= q_res_s;
                    rem_r  <= r_res_s;
                    dbz_r  <= zero_r;
                    ovfl_r <= ovf_r;
                    done_r <= 1'b1;
                    busy_r <= 1'b0;
                end
                default: begin
                    done_r <= 1'b0;
                    busy_r <= 1'b0;
                end
            endcase
        end
    end

    assign Busy      = busy_r;
    assign Done      = done_r;
    assign Quotient  = quot_r;
    assign Remainder = rem_r;
    assign DivByZero = dbz_r;
    assign Overflow  = ovfl_r;

endmodule

// File: tb/tb_iterative_divider.sv
// Directed self-checking bench for iterative_divider (l = 16).
module tb_iterative_divider;

    logic        Clock = 1'b0;
    logic        Reset = 1'b1;
    logic        Start = 1'b0;
    logic        Signed = 1'b0;
    logic [15:0] Dividend = 16'h0000;
    logic [15:0] Divisor = 16'h0000;
    logic        Busy, Done, DivByZero, Overflow;
    logic [15:0] Quotient, Remainder;

    int n_checks = 0;
    int n_errors = 0;

    iterative_divider #(.l(16)) dut (
        .Clock(Clock), .Reset(Reset), .Start(Start), .Signed(Signed),
        .Dividend(Dividend), .Divisor(Divisor), .Busy(Busy), .Done(Done),
        .Quotient(Quotient), .Remainder(Remainder),
        .DivByZero(DivByZero), .Overflow(Overflow)
    );

    always #5 Clock = ~Clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // drive a request before edge 1, then scramble operands afterwards
    task automatic start_op(input logic sg, input logic [15:0] a, input logic [15:0] b);
        Signed = sg; Dividend = a; Divisor = b; Start = 1'b1;
        @(posedge Clock);
        @(negedge Clock);
        Start = 1'b0; Dividend = 16'h5A5A; Divisor = 16'h0000; Signed = ~sg;
    endtask

    // wait (bounded) for Done; lat = edges since Start edge, busy_cnt = cycles with Busy before Done
    task automatic wait_done(input bit pulse, output int lat, output int busy_cnt);
        lat = 1;
        busy_cnt = 0;
        while (!Done && lat < 40) begin
            if (Busy) busy_cnt++;
            if (pulse && (lat == 3 || lat == 10)) begin
                Start = 1'b1; Dividend = 16'hFFFF; Divisor = 16'h0001;
            end else begin
                Start = 1'b0;
            end
            @(negedge Clock);
            lat++;
        end
        Start = 1'b0;
    endtask

    task automatic do_op(input string tag, input logic sg, input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] eq, input logic [15:0] er, input logic ez, input logic eo,
                         input bit pulse, input bit hold_check);
        int lat, bc;
        start_op(sg, a, b);
        wait_done(pulse, lat, bc);
        check({tag, ".latency"}, lat, 32'd18);
        check({tag, ".busy_cycles"}, bc, 32'd17);
        check({tag, ".busy_at_done"}, {31'd0, Busy}, 32'd0);
        check({tag, ".quot"}, {16'd0, Quotient}, {16'd0, eq});
        check({tag, ".rem"}, {16'd0, Remainder}, {16'd0, er});
        check({tag, ".dbz"}, {31'd0, DivByZero}, {31'd0, ez});
        check({tag, ".ovf"}, {31'd0, Overflow}, {31'd0, eo});
        if (hold_check) begin
            @(negedge Clock);
            check({tag, ".done_pulse"}, {31'd0, Done}, 32'd0);
            check({tag, ".quot_hold"}, {16'd0, Quotient}, {16'd0, eq});
        end
    endtask

    initial begin
        int dones;
        repeat (2) @(negedge Clock);
        check("rst.busy", {31'd0, Busy}, 32'd0);
        check("rst.done", {31'd0, Done}, 32'd0);
        check("rst.quot", {16'd0, Quotient}, 32'd0);
        check("rst.rem", {16'd0, Remainder}, 32'd0);
        check("rst.flags", {30'd0, DivByZero, Overflow}, 32'd0);
        Reset = 1'b0;
        @(negedge Clock);

        do_op("u100_7",   1'b0, 16'd100,  16'd7,    16'd14,   16'd2,    1'b0, 1'b0, 1'b0, 1'b1);
        do_op("s-7_2",    1'b1, 16'hFFF9, 16'h0002, 16'hFFFD, 16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b1);
        do_op("s7_-2",    1'b1, 16'h0007, 16'hFFFE, 16'hFFFD, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b1);
        do_op("s-7_-2",   1'b1, 16'hFFF9, 16'hFFFE, 16'h0003, 16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b1);
        do_op("s_ovf",    1'b1, 16'h8000, 16'hFFFF, 16'h8000, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b1);
        do_op("u_8000",   1'b0, 16'h8000, 16'hFFFF, 16'h0000, 16'h8000, 1'b0, 1'b0, 1'b0, 1'b1);
        do_op("s_8000_2", 1'b1, 16'h8000, 16'h0002, 16'hC000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1);
        do_op("u_dbz",    1'b0, 16'd1234, 16'd0,    16'hFFFF, 16'd1234, 1'b1, 1'b0, 1'b0, 1'b1);
        do_op("s_dbz",    1'b1, 16'd1234, 16'd0,    16'hFFFF, 16'd1234, 1'b1, 1'b0, 1'b0, 1'b1);
        do_op("s_dbz_neg",1'b1, 16'hFB2E, 16'd0,    16'hFFFF, 16'hFB2E, 1'b1, 1'b0, 1'b0, 1'b1);
        do_op("u_busy_start", 1'b0, 16'd1000, 16'd3, 16'd333, 16'd1,    1'b0, 1'b0, 1'b1, 1'b1);

        // back-to-back: second Start lands in the Done cycle
        do_op("b2b_first",  1'b0, 16'd200, 16'd9, 16'd22, 16'd2, 1'b0, 1'b0, 1'b0, 1'b0);
        do_op("b2b_second", 1'b0, 16'd50,  16'd5, 16'd10, 16'd0, 1'b0, 1'b0, 1'b0, 1'b1);

        // asynchronous reset in the middle of RUN
        start_op(1'b0, 16'd999, 16'd7);
        repeat (7) @(negedge Clock);
        #1 Reset = 1'b1;
        #1;
        check("arst.busy", {31'd0, Busy}, 32'd0);
        check("arst.done", {31'd0, Done}, 32'd0);
        check("arst.quot", {16'd0, Quotient}, 32'd0);
        check("arst.rem", {16'd0, Remainder}, 32'd0);
        check("arst.flags", {30'd0, DivByZero, Overflow}, 32'd0);
        @(negedge Clock);
        Reset = 1'b0;
        dones = 0;
        for (int i = 0; i < 25; i++) begin
            @(negedge Clock);
            if (Done) dones++;
        end
        check("arst.no_done", dones, 32'd0);
        do_op("after_rst", 1'b0, 16'd255, 16'd16, 16'd15, 16'd15, 1'b0, 1'b0, 1'b0, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
